// File: rtl/duty_ctrl.sv
// Soft-started PWM compare controller with a latched fault state and a shadowed target.
// Define DUTY_SOFT_START_EN to add the RAMP state and the step parameter.
module duty_ctrl #(
    parameter int arr     = 200,
    parameter int cmp_max = 180
`ifdef DUTY_SOFT_START_EN
    , parameter int step  = 1
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        fault,
    input  logic [15:0] target,
    input  logic        target_valid,
    output logic        target_ready,
    output logic [15:0] compare,
    output logic        period_tick,
    output logic        running,
    output logic        faulted
);

`ifdef DUTY_SOFT_START_EN
    typedef enum logic [1:0] {
        OFF   = 2'd0,
        RAMP  = 2'd1,
        RUN   = 2'd2,
        FAULT = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        OFF   = 2'd0,
        RUN   = 2'd2,
        FAULT = 2'd3
    } state_t;
`endif

    localparam logic [15:0] arr_v     = 16'(arr);
    localparam logic [15:0] cmp_max_v = 16'(cmp_max);

    state_t      state;
    state_t      state_nx;
    logic [15:0] cnt;
    logic [15:0] shadow;
    logic [15:0] clamped;
    logic [15:0] compare_nx;

    assign period_tick  = (cnt == arr_v);
    assign clamped      = (shadow > cmp_max_v) ? cmp_max_v : shadow;
    assign running      = (state == RUN)
`ifdef DUTY_SOFT_START_EN
                          || (state == RAMP)
`endif
                          ;
    assign faulted      = (state == FAULT);
    assign target_ready = !faulted;

`ifdef DUTY_SOFT_START_EN
    localparam logic [16:0] step_v = 17'(step);

    // One ramp increment, saturated at the clamped target (17 bits so it cannot wrap).
    logic [16:0] ramp_sum;
    logic [15:0] ramp_val;
    assign ramp_sum = {1'b0, compare} + step_v;
    assign ramp_val = (ramp_sum > {1'b0, clamped}) ? clamped : ramp_sum[15:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            state   <= OFF;
            compare <= '0;
        end else begin
            cnt     <= period_tick ? 16'd0 : cnt + 16'd1;
            state   <= state_nx;
            compare <= compare_nx;
        end
    end

    // Shadow is wiped when the fault state is entered so a stale target never resumes.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
        end else if (state_nx == FAULT && state != FAULT) begin
            shadow <= '0;
        end else if (target_valid && target_ready) begin
            shadow <= target;
        end
    end

    always_comb begin
        state_nx   = state;
        compare_nx = compare;
        if (fault) begin
            state_nx   = FAULT;
            compare_nx = '0;
        end else begin
            case (state)
                OFF: begin
                    compare_nx = '0;
                    if (period_tick && enable) begin
`ifdef DUTY_SOFT_START_EN
                        compare_nx = ramp_val;
                        state_nx   = (ramp_val == clamped) ? RUN : RAMP;
`else
                        compare_nx = clamped;
                        state_nx   = RUN;
`endif
                    end
                end
`ifdef DUTY_SOFT_START_EN
                RAMP: begin
                    if (!enable) begin
                        state_nx   = OFF;
                        compare_nx = '0;
                    end else if (period_tick) begin
                        if (compare >= clamped) begin
                            compare_nx = clamped;
                            state_nx   = RUN;
                        end else begin
                            compare_nx = ramp_val;
                            if (ramp_val == clamped) begin
                                state_nx = RUN;
                            end
                        end
                    end
                end
`endif
                RUN: begin
                    if (!enable) begin
                        state_nx   = OFF;
                        compare_nx = '0;
                    end else if (period_tick) begin
                        compare_nx = clamped;
                    end
                end
                FAULT: begin
                    compare_nx = '0;
                    if (!enable) begin
                        state_nx = OFF;
                    end
                end
                default: begin
                    state_nx   = OFF;
                    compare_nx = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_duty_ctrl.sv
// Directed bench for duty_ctrl (arr=200, cmp_max=180, step=10 when soft start is built in).
module tb_duty_ctrl;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        fault;
    logic [15:0] target;
    logic        target_valid;
    logic        target_ready;
    logic [15:0] compare;
    logic        period_tick;
    logic        running;
    logic        faulted;

    int total;
    int bad;

`ifdef DUTY_SOFT_START_EN
    localparam logic [15:0] FIRST_CMP = 16'd10;
`else
    localparam logic [15:0] FIRST_CMP = 16'd100;
`endif

    duty_ctrl #(
        .arr(200),
        .cmp_max(180)
`ifdef DUTY_SOFT_START_EN
        , .step(10)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .fault(fault),
        .target(target),
        .target_valid(target_valid),
        .target_ready(target_ready),
        .compare(compare),
        .period_tick(period_tick),
        .running(running),
        .faulted(faulted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_target(input logic [15:0] v);
        target       = v;
        target_valid = 1'b1;
        cycle(1);
        target_valid = 1'b0;
    endtask

    // Advances to just after the edge on which the period boundary is taken.
    task automatic wait_boundary(output bit ok);
        ok = period_tick;
        for (int i = 0; i < 250 && !ok; i++) begin
            @(posedge clk);
            #1;
            ok = period_tick;
        end
        if (ok) cycle(1);
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; fault = 1'b0; target = '0; target_valid = 1'b0;
        cycle(2);
        total++; if (compare !== 16'd0) begin bad++; $display("[TB] FAIL reset_compare got=%0d want=0", compare); end
        total++; if (period_tick !== 1'b0) begin bad++; $display("[TB] FAIL reset_tick got=%b want=0", period_tick); end
        total++; if (running !== 1'b0) begin bad++; $display("[TB] FAIL reset_running got=%b want=0", running); end
        total++; if (faulted !== 1'b0) begin bad++; $display("[TB] FAIL reset_faulted got=%b want=0", faulted); end
        total++; if (target_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready got=%b want=1", target_ready); end
        rst = 1'b0;
    endtask

`ifdef DUTY_SOFT_START_EN
    task automatic test_soft_start();
        bit ok;
        write_target(16'd100);
        enable = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            wait_boundary(ok);
            total++; if (!ok) begin bad++; $display("[TB] FAIL ramp_timeout step=%0d", i); end
            total++; if (compare !== 16'(10 * i)) begin bad++; $display("[TB] FAIL ramp_step%0d got=%0d want=%0d", i, compare, 10 * i); end
        end
        total++; if (running !== 1'b1) begin bad++; $display("[TB] FAIL ramp_running got=%b want=1", running); end
        wait_boundary(ok);
        total++; if (compare !== 16'd100) begin bad++; $display("[TB] FAIL ramp_hold got=%0d want=100", compare); end
    endtask
`else
    task automatic test_direct_start();
        bit ok;
        write_target(16'd100);
        enable = 1'b1;
        wait_boundary(ok);
        total++; if (compare !== 16'd100) begin bad++; $display("[TB] FAIL direct_first got=%0d want=100", compare); end
        total++; if (running !== 1'b1) begin bad++; $display("[TB] FAIL direct_running got=%b want=1", running); end
        cycle(15);
        enable = 1'b0;
        cycle(1);
        total++; if (compare !== 16'd0) begin bad++; $display("[TB] FAIL direct_disable got=%0d want=0", compare); end
        total++; if (running !== 1'b0) begin bad++; $display("[TB] FAIL direct_off got=%b want=0", running); end
        enable = 1'b1;
        wait_boundary(ok);
        total++; if (compare !== 16'd100) begin bad++; $display("[TB] FAIL direct_restart got=%0d want=100", compare); end
    endtask
`endif

    task automatic test_clamp();
        bit ok;
        write_target(16'd250);
        wait_boundary(ok);
        total++; if (compare !== 16'd180) begin bad++; $display("[TB] FAIL clamp_max got=%0d want=180", compare); end
        cycle(5);
        write_target(16'd50);
        cycle(3);
        total++; if (compare !== 16'd180) begin bad++; $display("[TB] FAIL clamp_midperiod got=%0d want=180", compare); end
        wait_boundary(ok);
        total++; if (compare !== 16'd50) begin bad++; $display("[TB] FAIL clamp_lower got=%0d want=50", compare); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        cycle(10);
        write_target(16'd60);
        cycle(3);
        total++; if (compare !== 16'd50) begin bad++; $display("[TB] FAIL b2b_midperiod got=%0d want=50", compare); end
        write_target(16'd70);
        wait_boundary(ok);
        total++; if (compare !== 16'd70) begin bad++; $display("[TB] FAIL b2b_last_wins got=%0d want=70", compare); end
    endtask

    task automatic test_fault();
        bit ok;
        cycle(20);
        fault = 1'b1;
        cycle(1);
        fault = 1'b0;
        total++; if (compare !== 16'd0) begin bad++; $display("[TB] FAIL fault_compare got=%0d want=0", compare); end
        total++; if (faulted !== 1'b1) begin bad++; $display("[TB] FAIL fault_flag got=%b want=1", faulted); end
        total++; if (target_ready !== 1'b0) begin bad++; $display("[TB] FAIL fault_ready got=%b want=0", target_ready); end
        wait_boundary(ok);
        total++; if (faulted !== 1'b1 || compare !== 16'd0) begin bad++; $display("[TB] FAIL fault_latched faulted=%b compare=%0d want 1/0", faulted, compare); end
        write_target(16'd90);
        enable = 1'b0;
        cycle(1);
        total++; if (faulted !== 1'b0 || running !== 1'b0) begin bad++; $display("[TB] FAIL fault_exit faulted=%b running=%b want 0/0", faulted, running); end
        enable = 1'b1;
        wait_boundary(ok);
        total++; if (running !== 1'b1 || compare !== 16'd0) begin bad++; $display("[TB] FAIL fault_shadow_clr running=%b compare=%0d want 1/0", running, compare); end
        enable = 1'b0;
        cycle(1);
    endtask

    task automatic test_fault_priority();
        bit ok;
        write_target(16'd40);
        enable = 1'b1;
        wait_boundary(ok);
        total++; if (running !== 1'b1) begin bad++; $display("[TB] FAIL prio_running got=%b want=1", running); end
        fault  = 1'b1;
        enable = 1'b0;
        cycle(1);
        total++; if (faulted !== 1'b1) begin bad++; $display("[TB] FAIL prio_fault_wins got=%b want=1", faulted); end
        fault = 1'b0;
        cycle(1);
        total++; if (faulted !== 1'b0 || running !== 1'b0) begin bad++; $display("[TB] FAIL prio_exit faulted=%b running=%b want 0/0", faulted, running); end
    endtask

    task automatic test_mid_reset();
        bit ok;
        int n;
        write_target(16'd100);
        enable = 1'b1;
        wait_boundary(ok);
        total++; if (compare !== FIRST_CMP) begin bad++; $display("[TB] FAIL mrst_before got=%0d want=%0d", compare, FIRST_CMP); end
        cycle(30);
        rst = 1'b1;
        cycle(1);
        rst = 1'b0;
        total++; if (compare !== 16'd0 || running !== 1'b0 || faulted !== 1'b0) begin bad++; $display("[TB] FAIL mrst_outputs compare=%0d running=%b faulted=%b want 0/0/0", compare, running, faulted); end
        total++; if (target_ready !== 1'b1 || period_tick !== 1'b0) begin bad++; $display("[TB] FAIL mrst_ready_tick ready=%b tick=%b want 1/0", target_ready, period_tick); end
        n = 0;
        for (int i = 0; i < 250; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (period_tick) break;
        end
        total++; if (n !== 200) begin bad++; $display("[TB] FAIL mrst_counter edges=%0d want=200", n); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        cycle(1);
`ifdef DUTY_SOFT_START_EN
        test_soft_start();
`else
        test_direct_start();
`endif
        test_clamp();
        test_back_to_back();
        test_fault();
        test_fault_priority();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
